onehot_scan_decoder: RTL and testbench
======================================

# onehot_scan_decoder

Parametrised binary-to-one-hot decoder with registered outputs, generalising our 2-to-4 gate-level decoder to 2^SEL_W lines. It has two modes: DIRECT decodes a select value accepted over a valid/ready handshake, and SCAN auto-rotates the active line at a programmable rate (multiplexed display digit drive, row strobing). It sits between control logic and one-hot enable fan-out, so all outputs are glitch-free flops.

## Interface
- SEL_W, 2, select width; number of output lines N = 2^SEL_W (legal 1..6)
- DIV_W, 4, width of the scan-rate divisor
- ACTIVE_LOW, 0, 1 = q lines active-low (inactive level is all ones)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; 0 blanks q
- mode  in  1  0 = DIRECT, 1 = SCAN
- sel_in  in  SEL_W  select value for DIRECT
- sel_valid  in  1  sel_in valid
- sel_ready  out  1  combinational: en & ~mode
- div  in  DIV_W  scan dwell minus one; each line is held div+1 cycles
- q  out  N  one-hot (or one-cold) decoded lines, registered
- idx  out  SEL_W  index currently driven, registered
- wrap  out  1  one-cycle pulse when SCAN wraps idx from N-1 to 0

## Operation
- State register: IDLE, DIRECT, SCAN. Next state each cycle: en=0 -> IDLE; en=1, mode=0 -> DIRECT; en=1, mode=1 -> SCAN.
- Reset (async, immediate): state=IDLE, q=inactive (all 0, or all 1 if ACTIVE_LOW), idx=0, wrap=0, prescaler=0.
- IDLE: q=inactive, idx held, prescaler=0, wrap=0.
- DIRECT:
  - Handshake completes on a clock edge with sel_valid & sel_ready. Then idx<=sel_in and q<=decode(sel_in).
  - With no transfer, q<=decode(idx): re-entry from IDLE resumes the last index.
  - Prescaler is held at 0; wrap=0.
- SCAN:
  - Prescaler cnt counts up each cycle.
  - When cnt >= div: cnt<=0 and idx<=idx+1 mod N. The compare is >= so a mid-count decrease of div advances on the next cycle.
  - q<=decode(next idx) in the same edge, so q always equals decode(idx).
  - wrap<=1 for exactly the edge where idx goes N-1 -> 0.
  - sel_valid is ignored.
- Entering SCAN from IDLE or DIRECT: the first cycle drives decode(idx) with cnt=0, so the current index dwells a full div+1 cycles.
- decode(k): bit k active, all others inactive. Exactly one active bit whenever state != IDLE. Width N = 1<<SEL_W, and idx arithmetic wraps naturally.
- Polarity: ACTIVE_LOW inverts q only. idx and wrap are unaffected.

## Timing
- All outputs except sel_ready are registered. Latency from the accepting edge to q/idx update is 1 cycle.
- en falling: q is inactive from the next edge. en rising: q is active from the next edge.
- mode switch with en=1 takes effect on the next edge. idx is preserved across mode switches, and cnt clears on leaving SCAN.
- Simultaneous handshake and mode=1 is impossible because sel_ready=0. Simultaneous en=0 and sel_valid: no transfer.
- rst asserted mid-scan: outputs go to reset values immediately. After release, the first active edge follows the state rules above.
- div=0: idx advances every cycle; the wrap period is N cycles.
- div=2^DIV_W-1: dwell is 2^DIV_W cycles per line.

## Test plan
- Reset, SEL_W=2: assert rst mid-operation -> q=0000, idx=0, wrap=0 asynchronously. With ACTIVE_LOW=1 -> q=1111.
- DIRECT: en=1, mode=0, present sel_in=2 with valid -> next cycle q=0100, idx=2. Then drop valid -> q holds 0100. Then sel_in=3 -> q=1000.
- SCAN div=0: from idx=0, q sequence is 0001, 0010, 0100, 1000, 0001 on consecutive cycles. wrap=1 only in the cycle q returns to 0001.
- SCAN div=2: each q value is held exactly 3 cycles. Change div 2->0 while cnt=1 -> advance on the next edge.
- en toggle: in SCAN at idx=1, drop en for 4 cycles -> q=0000, idx stays 1. Re-enable -> q=0010 with a full dwell.
- SEL_W=3 mode mix: DIRECT load 5 (q=00100000), switch to SCAN div=0 -> 6, 7, 0 with wrap pulse. Switch back to DIRECT -> q holds decode(current idx).

Source files
------------

// File: rtl/onehot_scan_decoder.sv
// Parametrised binary-to-one-hot decoder with registered lines, DIRECT (handshaked
// select) and SCAN (auto-rotating, programmable dwell) modes.

module onehot_scan_decoder_line #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic hit,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= ACTIVE_LOW;
      else     q <= hit ^ ACTIVE_LOW;
   end

endmodule

module onehot_scan_decoder #(
   parameter int SEL_W      = 2,
   parameter int DIV_W      = 4,
   parameter bit ACTIVE_LOW = 1'b0,
   localparam int N         = 1 << SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel_in,
   input  logic             sel_valid,
   output logic             sel_ready,
   input  logic [DIV_W-1:0] div,
   output logic [N-1:0]     q,
   output logic [SEL_W-1:0] idx,
   output logic             wrap
);

   typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

   state_t           state, state_nxt;
   logic [SEL_W-1:0] idx_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic             wrap_nxt;
   logic [N-1:0]     hit;

   assign sel_ready = en & ~mode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Outputs are computed from the state being entered, so every line flop
   // already reflects the new mode on the edge that switches it.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = '0;
      wrap_nxt  = 1'b0;
      if (!en) begin
         state_nxt = S_IDLE;
      end else if (!mode) begin
         state_nxt = S_DIRECT;
         if (sel_valid) idx_nxt = sel_in;
      end else begin
         state_nxt = S_SCAN;
         // First SCAN cycle leaves cnt at 0 so the current index gets a full dwell.
         if (state == S_SCAN) begin
            if (cnt >= div) begin
               idx_nxt  = idx + 1'b1;
               wrap_nxt = &idx;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx  <= '0;
         cnt  <= '0;
         wrap <= 1'b0;
      end else begin
         idx  <= idx_nxt;
         cnt  <= cnt_nxt;
         wrap <= wrap_nxt;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_line
      assign hit[k] = (state_nxt != S_IDLE) && (idx_nxt == SEL_W'(k));
      onehot_scan_decoder_line #(.ACTIVE_LOW(ACTIVE_LOW)) u_line (
         .clk (clk),
         .rst (rst),
         .hit (hit[k]),
         .q   (q[k])
      );
   end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Randomised and directed bench for onehot_scan_decoder: a 4-line active-high and an
// 8-line active-low instance share stimulus and are checked against a behavioural model.

module tb_onehot_scan_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, mode, sel_valid;
   logic [2:0] sel_in;
   logic [3:0] div;
   logic       rdy_a, rdy_b, wrap_a, wrap_b;
   logic [3:0] q_a;
   logic [1:0] idx_a;
   logic [7:0] q_b;
   logic [2:0] idx_b;

   always #5 clk = ~clk;

   onehot_scan_decoder #(.SEL_W(2), .DIV_W(4), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in[1:0]),
      .sel_valid(sel_valid), .sel_ready(rdy_a), .div(div), .q(q_a), .idx(idx_a), .wrap(wrap_a)
   );

   onehot_scan_decoder #(.SEL_W(3), .DIV_W(4), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
      .sel_valid(sel_valid), .sel_ready(rdy_b), .div(div), .q(q_b), .idx(idx_b), .wrap(wrap_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: per instance, the line currently pointed at, whether lines are lit,
   // whether we have already spent a cycle in SCAN, and the dwell counter.
   int NL[2] = '{4, 8};
   int m_idx[2], m_cnt[2];
   bit m_act[2], m_scan[2], m_wrap[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_idx[i] = 0; m_cnt[i] = 0; m_act[i] = 0; m_scan[i] = 0; m_wrap[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         m_wrap[i] = 0;
         if (!en) begin
            m_act[i] = 0; m_scan[i] = 0; m_cnt[i] = 0;
         end else if (!mode) begin
            m_act[i] = 1; m_scan[i] = 0; m_cnt[i] = 0;
            if (sel_valid) m_idx[i] = int'(sel_in) % NL[i];
         end else begin
            m_act[i] = 1;
            if (!m_scan[i]) begin
               m_scan[i] = 1; m_cnt[i] = 0;
            end else if (m_cnt[i] >= int'(div)) begin
               m_cnt[i]  = 0;
               m_wrap[i] = (m_idx[i] == NL[i] - 1);
               m_idx[i]  = (m_idx[i] + 1) % NL[i];
            end else begin
               m_cnt[i]++;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] ea, eb;
      ea = m_act[0] ? (32'd1 << m_idx[0]) : 32'd0;
      eb = (m_act[1] ? (32'd1 << m_idx[1]) : 32'd0) ^ 32'hFF;
      chk({tag, ".q_a"},   32'(q_a),    ea);
      chk({tag, ".idx_a"}, 32'(idx_a),  32'(m_idx[0]));
      chk({tag, ".wrap_a"},32'(wrap_a), 32'(m_wrap[0]));
      chk({tag, ".q_b"},   32'(q_b),    eb);
      chk({tag, ".idx_b"}, 32'(idx_b),  32'(m_idx[1]));
      chk({tag, ".wrap_b"},32'(wrap_b), 32'(m_wrap[1]));
      chk({tag, ".rdy"},   32'({rdy_a, rdy_b}), {30'd0, {2{en & ~mode}}});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Called just after a check (away from any edge); verifies the reset is immediate.
   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      chk({tag, ".lit_a"}, 32'(q_a), 32'h0);
      chk({tag, ".lit_b"}, 32'(q_b), 32'hFF);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 0; mode = 0; sel_valid = 0; sel_in = 0; div = 0;
      #1;
      model_reset();
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // DIRECT loads and holds
      en = 1; mode = 0; sel_in = 2; sel_valid = 1;
      step("dir2");
      chk("dir2.lit", 32'(q_a), 32'b0100);
      sel_valid = 0; sel_in = 1;
      step("dirhold");
      chk("dirhold.lit", 32'(q_a), 32'b0100);
      sel_in = 3; sel_valid = 1;
      step("dir3");
      chk("dir3.lit", 32'(q_a), 32'b1000);

      // SCAN div=0 from idx 0
      sel_in = 0; step("dir0");
      sel_valid = 0; mode = 1; div = 0;
      for (int k = 0; k < 5; k++) step("scan0");
      chk("scan0.wrap_lit", 32'(wrap_a), 32'd1);
      chk("scan0.q_lit", 32'(q_a), 32'b0001);

      // SCAN div=2, then shrink div mid-count
      div = 2;
      for (int k = 0; k < 9; k++) step("scan2");
      for (int k = 0; k < 8 && m_cnt[0] != 1; k++) step("seek_cnt1");
      chk("seek_cnt1.reach", 32'(m_cnt[0]), 32'd1);
      div = 0;
      step("divdrop");
      step("divdrop2");

      // en toggle while scanning at idx 1
      div = 3;
      for (int k = 0; k < 40 && idx_a != 2'd1; k++) step("seek_idx1");
      chk("seek_idx1.reach", 32'(idx_a), 32'd1);
      en = 0;
      for (int k = 0; k < 4; k++) step("blank");
      chk("blank.idx_lit", 32'(idx_a), 32'd1);
      en = 1;
      for (int k = 0; k < 6; k++) step("reen");

      // 8-line instance: load 5, scan through wrap, back to DIRECT
      mode = 0; sel_in = 5; sel_valid = 1;
      step("b_dir5");
      chk("b_dir5.lit", 32'(q_b), 32'hDF);
      sel_valid = 0; mode = 1; div = 0;
      for (int k = 0; k < 4; k++) step("b_scan");
      chk("b_scan.wrap_lit", 32'(wrap_b), 32'd1);
      mode = 0;
      for (int k = 0; k < 2; k++) step("b_back");

      // reset in the middle of a scan
      mode = 1; div = 1;
      for (int k = 0; k < 5; k++) step("prerst");
      async_reset("midrst");
      step("postrst");

      // randomised traffic
      for (int cyc = 0; cyc < 800; cyc++) begin
         if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
         en        = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) mode = ~mode;
         sel_valid = $urandom_range(0, 1);
         sel_in    = 3'($urandom);
         if ($urandom_range(0, 9) == 0)
            div = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 3));
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
